instr_encoder: RTL and testbench

- Producer end of the decoder's instruction interface: takes mnemonic-level fields (op, registers, immediate) and encodes them into 32-bit instruction words.
- Queues the encoded words in a small FIFO and presents them one per cycle to the instruction decoder.
- Expands the pseudo-op LI (32-bit load) into a MOV/MOVT pair.
- Used as the stimulus/fetch front end for decoder + register file + execute integration.

---
 rtl/instr_encoder.sv | 200 ++++++++++++++++++++
 tb/tb_instr_encoder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: turns mnemonic-level requests into 32-bit instruction words,
// expands LI into a MOV/MOVT pair and queues the words in a small FIFO.
// Optional feature macro: INSTR_ENC_ERR_COUNT_EN adds a saturating err_count output.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic          in_reg_form,
  input  logic [2:0]    in_rd,
  input  logic [2:0]    in_rn,
  input  logic [2:0]    in_rm,
  input  logic [31:0]   in_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   instruction,
  output logic          err_illegal,
`ifdef INSTR_ENC_ERR_COUNT_EN
  output logic [7:0]    err_count,
`endif
  output logic [CW-1:0] fifo_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [0:0] {IDLE, LI_HI} state_t;

  state_t        state_reg, state_next;
  logic [2:0]    li_rd_reg;
  logic [15:0]   li_hi_reg;
  logic          li_load;
  logic          illegal_accept;
  logic          err_illegal_reg;

  logic [31:0]   enc_word;
  logic [3:0]    alu_sub;
  logic          op_legal;
  logic          op_is_li;

  logic          push, pop, full;
  logic [31:0]   push_word;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [31:0]   fifo_words [DEPTH];

  // Field order: [31]=0, reg-form, ALU class, sub-op, rd, rn, rm, imm16.
  function automatic logic [31:0] pack_word(input logic reg_form, input logic alu,
                                            input logic [3:0] sub_op, input logic [2:0] rd,
                                            input logic [2:0] rn, input logic [2:0] rm,
                                            input logic [15:0] imm);
    return {1'b0, reg_form, alu, sub_op, rd, rn, rm, imm};
  endfunction

  // ADD..XOR map onto ALU sub-ops 1..5 in mnemonic order.
  assign alu_sub = in_op - 4'd3;

  // Encode the current request; LI yields its lower MOV half here.
  always_comb begin
    enc_word = '0;
    op_legal = 1'b1;
    op_is_li = 1'b0;
    case (in_op)
      4'd0: enc_word = pack_word(1'b0, 1'b0, 4'd0, in_rd, 3'd0, 3'd0, in_imm[15:0]);
      4'd1: enc_word = pack_word(1'b0, 1'b0, 4'd1, in_rd, 3'd0, 3'd0, in_imm[15:0]);
      4'd2: enc_word = pack_word(1'b0, 1'b0, 4'd2, in_rd, 3'd0, 3'd0, 16'd0);
      4'd3: enc_word = pack_word(1'b0, 1'b0, 4'd3, in_rd, 3'd0, 3'd0, 16'd0);
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
        if (in_reg_form)
          enc_word = pack_word(1'b1, 1'b1, alu_sub, in_rd, in_rn, in_rm, 16'd0);
        else
          enc_word = pack_word(1'b0, 1'b1, alu_sub, in_rd, in_rn, 3'd0, in_imm[15:0]);
      end
      // NOT is unary: always reg-form with an empty rm slot.
      4'd9: enc_word = pack_word(1'b1, 1'b1, 4'd6, in_rd, in_rn, 3'd0, 16'd0);
      4'd10: begin
        enc_word = pack_word(1'b0, 1'b0, 4'd0, in_rd, 3'd0, 3'd0, in_imm[15:0]);
        op_is_li = 1'b1;
      end
      default: op_legal = 1'b0;
    endcase
  end

  // Next-state, request handshake and FIFO push selection.
  always_comb begin
    state_next     = state_reg;
    in_ready       = 1'b0;
    push           = 1'b0;
    push_word      = enc_word;
    li_load        = 1'b0;
    illegal_accept = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = !full && !rst;
        if (in_valid && in_ready) begin
          if (!op_legal) begin
            illegal_accept = 1'b1;
          end else begin
            push = 1'b1;
            if (op_is_li) begin
              li_load    = 1'b1;
              state_next = LI_HI;
            end
          end
        end
      end
      LI_HI: begin
        push_word = pack_word(1'b0, 1'b0, 4'd1, li_rd_reg, 3'd0, 3'd0, li_hi_reg);
        if (!full) begin
          push       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, LI upper-half latch and illegal-op pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      li_rd_reg       <= '0;
      li_hi_reg       <= '0;
      err_illegal_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      err_illegal_reg <= illegal_accept;
      if (li_load) begin
        li_rd_reg <= in_rd;
        li_hi_reg <= in_imm[31:16];
      end
    end
  end

  assign err_illegal = err_illegal_reg;

`ifdef INSTR_ENC_ERR_COUNT_EN
  logic [7:0] err_count_reg;

  // Saturating count of accepted illegal ops.
  always_ff @(posedge clk) begin
    if (rst)
      err_count_reg <= '0;
    else if (illegal_accept && err_count_reg != 8'hFF)
      err_count_reg <= err_count_reg + 8'd1;
  end

  assign err_count = err_count_reg;
`endif

  // Fullness uses the registered count only, so a same-cycle pop never frees a slot early.
  assign full      = (count_reg == CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid && out_ready;

  // Occupancy update: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [31:0] entry_reg;

      // Storage slot; contents are don't-care until written, the empty flag masks them.
      always_ff @(posedge clk) begin
        if (push && wr_ptr_reg == AW'(gi))
          entry_reg <= push_word;
      end

      assign fifo_words[gi] = entry_reg;
    end
  endgenerate

  assign instruction = out_valid ? fifo_words[rd_ptr_reg] : 32'd0;
  assign fifo_count  = count_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder with directed and random requests.
`timescale 1ns/1ps
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = '0;
  logic          in_reg_form = 1'b0;
  logic [2:0]    in_rd = '0;
  logic [2:0]    in_rn = '0;
  logic [2:0]    in_rm = '0;
  logic [31:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   instruction;
  logic          err_illegal;
  logic [CW-1:0] fifo_count;
`ifdef INSTR_ENC_ERR_COUNT_EN
  logic [7:0]    err_count;
`endif

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_reg_form (in_reg_form),
    .in_rd       (in_rd),
    .in_rn       (in_rn),
    .in_rm       (in_rm),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instruction (instruction),
    .err_illegal (err_illegal),
`ifdef INSTR_ENC_ERR_COUNT_EN
    .err_count   (err_count),
`endif
    .fifo_count  (fifo_count)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic        err_exp = 1'b0;
  int          err_total = 0;
  bit          rand_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Build a word from its documented bit fields.
  function automatic logic [31:0] mk(input int rf, input int alu, input int sub,
                                     input int rd, input int rn, input int rm, input int imm16);
    return (32'(rf) << 30) | (32'(alu) << 29) | (32'(sub) << 25) | (32'(rd) << 22) |
           (32'(rn) << 19) | (32'(rm) << 16) | (32'(imm16) & 32'hFFFF);
  endfunction

  // Reference: the word(s) a request must produce, or an illegal flag.
  task automatic model_issue(input int op, input int rf, input int rd, input int rn,
                             input int rm, input logic [31:0] imm, output bit illegal);
    int lo;
    int hi;
    lo = int'(imm & 32'hFFFF);
    hi = int'(imm >> 16);
    illegal = 1'b0;
    if (op == 0 || op == 1)       exp_q.push_back(mk(0, 0, op, rd, 0, 0, lo));
    else if (op == 2 || op == 3)  exp_q.push_back(mk(0, 0, op, rd, 0, 0, 0));
    else if (op == 9)             exp_q.push_back(mk(1, 1, 6, rd, rn, 0, 0));
    else if (op >= 4 && op <= 8) begin
      if (rf != 0) exp_q.push_back(mk(1, 1, op - 3, rd, rn, rm, 0));
      else         exp_q.push_back(mk(0, 1, op - 3, rd, rn, 0, lo));
    end else if (op == 10) begin
      exp_q.push_back(mk(0, 0, 0, rd, 0, 0, lo));
      exp_q.push_back(mk(0, 0, 1, rd, 0, 0, hi));
    end else illegal = 1'b1;
  endtask

  // Issue tracker: every accepted request loads its expected words into the scoreboard.
  always @(negedge clk) begin
    bit ill;
    ill = 1'b0;
    if (rst) begin
      exp_q.delete();
      err_total = 0;
    end else if (in_valid && in_ready) begin
      model_issue(int'(in_op), int'(in_reg_form), int'(in_rd), int'(in_rn), int'(in_rm), in_imm, ill);
      if (ill) err_total++;
    end
    err_exp <= ill;
  end

  // Monitor: pops and compares whenever the DUT hands over a word.
  always @(negedge clk) begin
    logic [31:0] req;
    if (!rst) begin
      chk("err_illegal pulse", 32'(err_illegal), 32'(err_exp));
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected word: got 0x%08h, expected no word", instruction);
          end else begin
            req = exp_q.pop_front();
            chk("scoreboard word", instruction, req);
          end
        end
      end else begin
        chk("empty instruction", instruction, 32'h0);
      end
    end
  end

  task automatic send(input int op, input int rf, input int rd, input int rn, input int rm,
                      input logic [31:0] imm);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    in_valid    = 1'b1;
    in_op       = 4'(op);
    in_reg_form = 1'(rf);
    in_rd       = 3'(rd);
    in_rn       = 3'(rn);
    in_rm       = 3'(rm);
    in_imm      = imm;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send timeout: op %0d not accepted, expected acceptance", op);
    end
  endtask

  task automatic expect_word(input string name, input logic [31:0] req);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        chk(name, instruction, req);
        seen = 1'b1;
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: got no word, expected 0x%08h", name, req);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset fifo_count", 32'(fifo_count), 32'h0);
    chk("reset instruction", instruction, 32'h0);
    chk("reset err_illegal", 32'(err_illegal), 32'h0);
    chk("in_ready during reset", 32'(in_ready), 32'h0);
`ifdef INSTR_ENC_ERR_COUNT_EN
    chk("reset err_count", 32'(err_count), 32'h0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready after reset", 32'(in_ready), 32'h1);

    // Single MOV
    send(0, 0, 0, 0, 0, 32'h0000_FFFF);
    expect_word("MOV R0 word", 32'h0000_FFFF);
    chk("MOV fifo_count", 32'(fifo_count), 32'h1);
    @(negedge clk);
    chk("MOV fifo_count after pop", 32'(fifo_count), 32'h0);

    // LI expansion
    send(10, 0, 0, 0, 0, 32'hEEEE_FFFF);
    fork
      begin
        @(negedge clk);
        chk("LI in_ready low", 32'(in_ready), 32'h0);
        @(negedge clk);
        chk("LI in_ready back", 32'(in_ready), 32'h1);
      end
      begin
        expect_word("LI low word", 32'h0000_FFFF);
        expect_word("LI high word", 32'h0200_EEEE);
      end
    join

    // ALU and move forms
    send(4, 0, 0, 0, 0, 32'h0000_0001);
    expect_word("ADD imm word", 32'h2200_0001);
    send(7, 1, 1, 0, 1, 32'h0000_ABCD);
    expect_word("OR reg word", 32'h6841_0000);
    send(9, 0, 0, 0, 5, 32'h0000_1234);
    expect_word("NOT word", 32'h6C00_0000);
    send(2, 0, 7, 3, 2, 32'h0000_1234);
    expect_word("CLR R7 word", 32'h05C0_0000);

    // Backpressure with a full FIFO
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int r = 0; r < 4; r++) send(3, 0, r, 0, 0, 32'h0);
    fork
      send(3, 0, 4, 0, 0, 32'h0);
      begin
        @(negedge clk);
        chk("full fifo_count", 32'(fifo_count), 32'h4);
        chk("full in_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int r = 0; r < 5; r++)
          expect_word($sformatf("SET R%0d order", r), 32'h0600_0000 + 32'(r) * 32'h0040_0000);
      end
    join

    // Illegal op
    send(12, 0, 3, 3, 3, 32'h0000_5555);
    @(negedge clk);
    chk("illegal err pulse", 32'(err_illegal), 32'h1);
    chk("illegal no word", 32'(out_valid), 32'h0);
`ifdef INSTR_ENC_ERR_COUNT_EN
    chk("illegal err_count", 32'(err_count), 32'h1);
`endif
    @(negedge clk);
    chk("illegal pulse ends", 32'(err_illegal), 32'h0);
    chk("illegal fifo_count", 32'(fifo_count), 32'h0);

    // Reset while the LI upper half is pending
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(3, 0, 0, 0, 0, 32'h0);
    send(10, 0, 2, 0, 0, 32'h1234_5678);
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready while rst", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst flush out_valid", 32'(out_valid), 32'h0);
    chk("rst flush fifo_count", 32'(fifo_count), 32'h0);
    chk("in_ready after mid-LI rst", 32'(in_ready), 32'h1);
`ifdef INSTR_ENC_ERR_COUNT_EN
    chk("rst err_count", 32'(err_count), 32'h0);
`endif
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no MOVT after rst", 32'(out_valid), 32'h0);
    end

    // Random requests with random consumer stalls
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
          send(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), $urandom);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (30) @(negedge clk);
    chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
    chk("final fifo_count", 32'(fifo_count), 32'h0);
`ifdef INSTR_ENC_ERR_COUNT_EN
    chk("random err_count", 32'(err_count), 32'((err_total > 255) ? 255 : err_total));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
